// File: rtl/cond_seq_fsm.sv
// Sequential per-channel comparator: snapshots NCH operands on start, then writes one
// TRUE_VAL/FALSE_VAL result per cycle into out1 and pulses done after the last channel.
module cond_seq_fsm #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NCH       = 4,
  parameter int unsigned MODE      = 0,
  parameter logic [63:0] CMP_VAL   = 64'd10,
  parameter logic [63:0] TRUE_VAL  = 64'd1,
  parameter logic [63:0] FALSE_VAL = 64'd2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [NCH*WIDTH-1:0]                   operand,
  output logic [NCH*WIDTH-1:0]                   out1,
  output logic                                   busy,
  output logic                                   done,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] chan_idx
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [WIDTH-1:0] CmpW   = CMP_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TrueW  = TRUE_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FalseW = FALSE_VAL[WIDTH-1:0];
  localparam logic [CW-1:0]    LastIdx = CW'(NCH - 1);

  typedef enum logic [7:0] {
    StInitial = 8'd0,
    StIdle    = 8'd1,
    StEval    = 8'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] snap_q [NCH];
  logic [WIDTH-1:0] res_q  [NCH];
  logic [WIDTH-1:0] cur_op;
  logic [WIDTH-1:0] wr_val;
  logic             cmp_true;
  logic             last_ch;

  // Mux rather than direct indexing keeps the select width independent of NCH.
  always_comb begin
    cur_op = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (chan_idx == CW'(i)) cur_op = snap_q[i];
    end
    cmp_true = (MODE == 0) ? (cur_op == CmpW) : (cur_op < CmpW);
    wr_val   = cmp_true ? TrueW : FalseW;
    last_ch  = (chan_idx == LastIdx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInitial;
      busy     <= 1'b0;
      done     <= 1'b0;
      chan_idx <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        snap_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        StInitial: begin
          for (int i = 0; i < int'(NCH); i++) res_q[i] <= '0;
          state_q <= StIdle;
        end
        StIdle: begin
          if (start) begin
            for (int i = 0; i < int'(NCH); i++) snap_q[i] <= operand[i*WIDTH +: WIDTH];
            chan_idx <= '0;
            busy     <= 1'b1;
            state_q  <= StEval;
          end
        end
        StEval: begin
          for (int i = 0; i < int'(NCH); i++) begin
            if (chan_idx == CW'(i)) res_q[i] <= wr_val;
          end
          if (last_ch) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            chan_idx <= '0;
            state_q  <= StIdle;
          end else begin
            chan_idx <= chan_idx + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : gen_out
    assign out1[g*WIDTH +: WIDTH] = res_q[g];
  end

endmodule

// File: tb/tb_cond_seq_fsm.sv
// Directed bench for cond_seq_fsm: MODE=0 and MODE=1 four-channel instances sharing
// stimulus, plus a single-channel 8-bit instance exercising result truncation.
module tb_cond_seq_fsm;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] operand;
  logic [127:0] out1_0, out1_1;
  logic         busy0, busy1, done0, done1;
  logic [1:0]   idx0, idx1;
  logic         start2;
  logic [7:0]   op2, out2;
  logic         busy2, done2;
  logic [0:0]   idx2;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp0 = '0;
  logic [127:0] exp1 = '0;

  cond_seq_fsm #(.WIDTH(32), .NCH(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .operand(operand),
    .out1(out1_0), .busy(busy0), .done(done0), .chan_idx(idx0)
  );

  cond_seq_fsm #(.WIDTH(32), .NCH(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .operand(operand),
    .out1(out1_1), .busy(busy1), .done(done1), .chan_idx(idx1)
  );

  cond_seq_fsm #(.WIDTH(8), .NCH(1), .MODE(0), .TRUE_VAL(64'h1FF)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .operand(op2),
    .out1(out2), .busy(busy2), .done(done2), .chan_idx(idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int unsigned o0, input int unsigned o1,
                         input int unsigned o2, input int unsigned o3);
    operand = {o3, o2, o1, o0};
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; operand = '0; op2 = '0;
    tick; tick;
    n_cmp++; if (out1_0 !== 128'd0) begin n_err++; $display("FAIL reset_out1: got %0h want 0", out1_0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done0); end
    n_cmp++; if (idx0 !== 2'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", idx0); end
    n_cmp++; if (out2 !== 8'd0) begin n_err++; $display("FAIL reset_out2: got %0h want 0", out2); end
    reset = 1'b0;
    tick;
    exp0 = '0; exp1 = '0;
  endtask

  task automatic test_mode0;
    int unsigned r0 [4] = '{1, 2, 1, 2};
    int unsigned r1 [4] = '{2, 1, 2, 1};
    set_ops(10, 0, 10, 7);
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL m0_accept_busy: got %b want 1", busy0); end
    n_cmp++; if (out1_0 !== exp0) begin n_err++; $display("FAIL m0_accept_out1: got %h want %h", out1_0, exp0); end
    for (int i = 0; i < 4; i++) begin
      tick;
      exp0[i*32 +: 32] = r0[i];
      exp1[i*32 +: 32] = r1[i];
      n_cmp++; if (out1_0 !== exp0) begin n_err++; $display("FAIL m0_out1[%0d]: got %h want %h", i, out1_0, exp0); end
      n_cmp++; if (busy0 !== (i != 3)) begin n_err++; $display("FAIL m0_busy[%0d]: got %b want %b", i, busy0, i != 3); end
      n_cmp++; if (done0 !== (i == 3)) begin n_err++; $display("FAIL m0_done[%0d]: got %b want %b", i, done0, i == 3); end
      n_cmp++; if (idx0 !== 2'((i + 1) % 4)) begin n_err++; $display("FAIL m0_idx[%0d]: got %0d want %0d", i, idx0, (i + 1) % 4); end
    end
    n_cmp++; if (out1_1 !== exp1) begin n_err++; $display("FAIL m0_dut1_out1: got %h want %h", out1_1, exp1); end
    tick;
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL m0_done_after: got %b want 0", done0); end
  endtask

  task automatic test_mode1;
    int unsigned r0 [4] = '{2, 1, 2, 2};
    int unsigned r1 [4] = '{1, 2, 1, 2};
    set_ops(9, 10, 0, 32'hFFFF_FFFF);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp0[i*32 +: 32] = r0[i];
      exp1[i*32 +: 32] = r1[i];
      n_cmp++; if (out1_1 !== exp1) begin n_err++; $display("FAIL m1_out1[%0d]: got %h want %h", i, out1_1, exp1); end
      n_cmp++; if (done1 !== (i == 3)) begin n_err++; $display("FAIL m1_done[%0d]: got %b want %b", i, done1, i == 3); end
    end
    n_cmp++; if (out1_0 !== exp0) begin n_err++; $display("FAIL m1_dut0_out1: got %h want %h", out1_0, exp0); end
    tick;
  endtask

  task automatic test_latch_and_ignore;
    int unsigned r0 [4] = '{1, 1, 2, 2};
    set_ops(10, 10, 0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    set_ops(10, 10, 10, 10);
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      tick;
      exp0[i*32 +: 32] = r0[i];
      n_cmp++; if (out1_0 !== exp0) begin n_err++; $display("FAIL latch_out1[%0d]: got %h want %h", i, out1_0, exp0); end
      n_cmp++; if (done0 !== (i == 3)) begin n_err++; $display("FAIL latch_done[%0d]: got %b want %b", i, done0, i == 3); end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL no_requeue_busy[%0d]: got %b want 0", k, busy0); end
      n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL no_requeue_done[%0d]: got %b want 0", k, done0); end
    end
  endtask

  task automatic test_reset_mid_pass;
    int unsigned r0 [4] = '{2, 1, 1, 2};
    set_ops(10, 0, 10, 7);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    n_cmp++; if (out1_0[63:0] !== {32'd2, 32'd1}) begin n_err++; $display("FAIL mid_two_written: got %h want %h", out1_0[63:0], {32'd2, 32'd1}); end
    reset = 1'b1;
    tick;
    exp0 = '0;
    n_cmp++; if (out1_0 !== 128'd0) begin n_err++; $display("FAIL mid_reset_out1: got %h want 0", out1_0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL mid_reset_done: got %b want 0", done0); end
    n_cmp++; if (idx0 !== 2'd0) begin n_err++; $display("FAIL mid_reset_idx: got %0d want 0", idx0); end
    reset = 1'b0;
    start = 1'b1;
    set_ops(7, 10, 10, 0);
    tick;
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL initial_ignores_start: got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL abandoned_no_done: got %b want 0", done0); end
    tick;
    start = 1'b0;
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL idle_accepts_start: got %b want 1", busy0); end
    for (int i = 0; i < 4; i++) begin
      tick;
      exp0[i*32 +: 32] = r0[i];
      n_cmp++; if (done0 !== (i == 3)) begin n_err++; $display("FAIL post_reset_done[%0d]: got %b want %b", i, done0, i == 3); end
    end
    n_cmp++; if (out1_0 !== exp0) begin n_err++; $display("FAIL post_reset_out1: got %h want %h", out1_0, exp0); end
  endtask

  task automatic test_back_to_back;
    set_ops(10, 0, 10, 7);
    exp0 = {32'd2, 32'd1, 32'd2, 32'd1};
    start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick;
      n_cmp++; if (done0 !== (k % 5 == 4)) begin n_err++; $display("FAIL b2b_done[%0d]: got %b want %b", k, done0, k % 5 == 4); end
      n_cmp++; if (busy0 !== (k % 5 != 4)) begin n_err++; $display("FAIL b2b_busy[%0d]: got %b want %b", k, busy0, k % 5 != 4); end
    end
    start = 1'b0;
    n_cmp++; if (out1_0 !== exp0) begin n_err++; $display("FAIL b2b_out1: got %h want %h", out1_0, exp0); end
    tick;
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL b2b_stop_busy: got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL b2b_stop_done: got %b want 0", done0); end
  endtask

  task automatic test_nch1_truncation;
    op2 = 8'd10;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL n1_accept_busy: got %b want 1", busy2); end
    n_cmp++; if (out2 !== 8'h00) begin n_err++; $display("FAIL n1_accept_out: got %h want 00", out2); end
    tick;
    n_cmp++; if (out2 !== 8'hFF) begin n_err++; $display("FAIL n1_trunc_out: got %h want ff", out2); end
    n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL n1_done: got %b want 1", done2); end
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL n1_busy_end: got %b want 0", busy2); end
    n_cmp++; if (idx2 !== 1'b0) begin n_err++; $display("FAIL n1_idx: got %0d want 0", idx2); end
    tick;
    n_cmp++; if (done2 !== 1'b0) begin n_err++; $display("FAIL n1_done_pulse: got %b want 0", done2); end
    op2 = 8'd11;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    tick;
    n_cmp++; if (out2 !== 8'h02) begin n_err++; $display("FAIL n1_false_out: got %h want 02", out2); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode1;
    test_latch_and_ignore;
    test_reset_mid_pass;
    test_back_to_back;
    test_nch1_truncation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cond_seq_fsm.md
COND_SEQ_FSM -- requirements
Module: cond_seq_fsm

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, data width per channel, legal range 1..64.
REQ-002 The block SHALL have parameter NCH, default 4, channel count, legal range 1..16.
REQ-003 The block SHALL have parameter MODE, default 0, compare mode: 0 = equal, 1 = unsigned less-than.
REQ-004 The block SHALL have parameter CMP_VAL, default 10, WIDTH-bit compare constant.
REQ-005 The block SHALL have parameter TRUE_VAL, default 1, the result written when the compare is true.
REQ-006 The block SHALL have parameter FALSE_VAL, default 2, the result written when the compare is false.

Interface
REQ-007 The block SHALL have one clock and a synchronous, active-high reset.
REQ-008 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 start  in  1  request to evaluate all channels.
REQ-011 operand  in  NCH*WIDTH  packed operands; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 out1  out  NCH*WIDTH  packed registered results, using the same packing as operand.
REQ-013 busy  out  1  high while channels are being evaluated.
REQ-014 done  out  1  one-cycle pulse when the last channel is written.
REQ-015 chan_idx  out  clog2(NCH) (minimum 1)  index of the channel being evaluated.

Function
REQ-016 The state register SHALL be 8 bits wide, with states INITIAL=0, IDLE=1, EVAL=2; all other encodings SHALL return to IDLE.
REQ-017 INITIAL: clears out1 to 0, then moves to IDLE on the next edge unconditionally; start is ignored in this state.
REQ-018 IDLE: when start=1, the block SHALL latch all of operand into an internal snapshot, set chan_idx<=0 and busy<=1, and move to EVAL.
REQ-019 IDLE with start=0: all registers hold.
REQ-020 EVAL, each edge: channel chan_idx of out1 <= TRUE_VAL if the compare is true, else FALSE_VAL; chan_idx increments.
REQ-021 Compare operation: (snapshot[chan_idx] == CMP_VAL) when MODE=0; (snapshot[chan_idx] < CMP_VAL), unsigned, when MODE=1.
REQ-022 Values written SHALL be TRUE_VAL/FALSE_VAL truncated to WIDTH bits.
REQ-023 Channels not yet written in the current pass SHALL hold their previous values.
REQ-024 On the edge that writes channel NCH-1, the block SHALL set done<=1, busy<=0, chan_idx<=0, and state<=IDLE.
REQ-025 done SHALL be high for exactly one cycle per pass.
REQ-026 Latency: start sampled at edge E0 -> channel i updated at edge E0+1+i -> done high for the cycle after edge E0+NCH.
REQ-027 start while in EVAL SHALL be ignored; no queuing.
REQ-028 start during a done-high cycle SHALL be accepted, giving back-to-back passes.
REQ-029 Operand changes after E0 SHALL NOT affect the current pass.
REQ-030 NCH=1: the pass SHALL take a single EVAL cycle, with done and busy timing per REQ-024/REQ-026.
REQ-031 The block SHALL use no internal clock generation and no simulation-only constructs.

Reset
REQ-032 reset=1 at an edge SHALL force state<=INITIAL, out1<=0, busy<=0, done<=0, chan_idx<=0, and clear the snapshot.
REQ-033 Reset SHALL override start and any EVAL activity in the same cycle; a pass in progress SHALL be abandoned with no done pulse.
REQ-034 After reset deasserts, the first start SHALL be accepted no earlier than the second edge (INITIAL then IDLE).

Verification (WIDTH=32, NCH=4, CMP_VAL=10, TRUE_VAL=1, FALSE_VAL=2 unless stated)
REQ-035 MODE=0: reset, then start with operands {10,0,10,7} (ch0..ch3) -> out1 ch0..ch3 = {1,2,1,2} over 4 successive edges; done pulses once; busy high for 4 cycles.
REQ-036 MODE=1: operands {9,10,0,0xFFFFFFFF} -> out1 = {1,2,1,2}, confirming the compare is unsigned.
REQ-037 Operands changed to all-10 one cycle after start -> results still reflect the latched operands; a start pulsed mid-EVAL -> no second pass.
REQ-038 reset asserted during EVAL after 2 channels have been written -> out1=0, busy=0, no done pulse; the next pass completes normally.
REQ-039 start held high continuously -> back-to-back passes, done every 5 cycles (1 IDLE-accept cycle + 4 EVAL cycles), with busy low only during the done cycle.
REQ-040 NCH=1, WIDTH=8, TRUE_VAL=0x1FF -> out1 = 0xFF (truncation); busy high for 1 cycle.
